led_pattern_engine: RTL and testbench
=====================================

LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 The block SHALL have parameter N_LED, default 10, giving the LED count (N_LED >= 2).
REQ-002 The block SHALL have parameter SEG_W, default 3, giving the lit-segment width for bounce/rotate modes (1 <= SEG_W <= N_LED-1).
REQ-003 The block SHALL have parameter DIV_W, default 21, giving the prescaler counter width.
REQ-004 iCLK  in  1  system clock, the only clock in the block; iRST_n  in  1  reset, asynchronous, active-low.
REQ-005 iMODE  in  2  pattern select: 00 bounce, 01 rotate-left, 10 rotate-right, 11 bar-fill.
REQ-006 iSPEED  in  4  speed select; a larger value gives a faster step rate.
REQ-007 iPAUSE  in  1  when high, freezes the prescaler and the pattern.
REQ-008 oLED  out  N_LED  current pattern, registered.
REQ-009 oDIR  out  1  bounce direction: 0 = toward MSB, 1 = toward LSB.
REQ-010 oTICK  out  1  one-cycle pulse asserted in the cycle oLED takes a stepped value.

Function
REQ-011 All state SHALL be clocked by iCLK only; no counter bit or divided signal SHALL be used as a clock.
REQ-012 The prescaler SHALL be a DIV_W-bit counter; LIMIT = (2^DIV_W - 1) >> iSPEED, with LIMIT = 0 when iSPEED >= DIV_W.
REQ-013 When not paused: if cnt >= LIMIT, the block SHALL raise a step, set cnt to 0, and register oTICK = 1 for one cycle; otherwise cnt SHALL increment and oTICK = 0.
REQ-014 A step SHALL update oLED on the same clock edge that oTICK rises.
REQ-015 LIMIT = 0 SHALL give a step on every clock; an iSPEED change SHALL take effect on the next compare, with no counter reload.
REQ-016 Bounce, DIR=0, step: if oLED[N_LED-1]=1, the block SHALL set DIR to 1 and shift oLED right by 1; else it SHALL shift oLED left by 1 with zero fill.
REQ-017 Bounce, DIR=1, step: if oLED[0]=1, the block SHALL set DIR to 0 and shift oLED left by 1; else it SHALL shift oLED right by 1 with zero fill.
REQ-018 Rotate-left and rotate-right SHALL rotate oLED circularly by 1 per step; oDIR SHALL be held at 0 in these modes.
REQ-019 Bar-fill SHALL step the thermometer code 0, 1, 3, ... up to all-ones, then wrap to all-zeros on the next step; oDIR SHALL be 0.
REQ-020 Mode change: the block SHALL register iMODE as cur_mode every clock; when iMODE differs from cur_mode, on that edge it SHALL load the init pattern of the new mode, set cnt to 0, set DIR to 0 and force oTICK to 0.
REQ-021 Mode change SHALL take priority over a step and over iPAUSE.
REQ-022 The init pattern SHALL be SEG_W ones in the LSBs (zeros above) for modes 00, 01 and 10, and all-zeros for mode 11.
REQ-023 iPAUSE=1 SHALL hold cnt, oLED and oDIR and force oTICK to 0; on release, counting SHALL resume from the held cnt.

Reset
REQ-024 On iRST_n=0, asynchronously: oLED = init pattern of mode 00, oDIR = 0, oTICK = 0, cnt = 0, cur_mode = 00.
REQ-025 After iRST_n is released, if iMODE != 00 the first clock SHALL apply the REQ-020 mode load.
REQ-026 Reset asserted mid-step or mid-pause SHALL override all other activity immediately.

Verification (N_LED=8, SEG_W=3, DIV_W=4)
REQ-027 Reset with iMODE=00 -> oLED=8'h07, oDIR=0; at iSPEED=0, oTICK pulses every 16 clocks.
REQ-028 Bounce, iSPEED=4 (LIMIT=0) -> oLED sequence 07,0E,1C,38,70,E0,70(oDIR=1),38,1C,0E,07,0E(oDIR=0).
REQ-029 Switch iMODE to 10 mid-run -> next clock oLED=07, oTICK=0, cnt=0; following steps give 83, C1, E0.
REQ-030 Mode 11, LIMIT=0 -> 00,01,03,07,0F,1F,3F,7F,FF,00.
REQ-031 iSPEED=2 (LIMIT=3) with iPAUSE held 10 clocks mid-count -> no oTICK and no oLED change while paused; the next tick comes exactly the remaining count after release.
REQ-032 Assert iRST_n low between clock edges during bounce with oDIR=1 -> oLED=07 and oDIR=0 with no clock edge needed.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// Pattern-control bus for led_pattern_engine.
// The master drives mode, speed and pause; the slave returns the LEDs, bounce direction and step tick.
interface led_pattern_engine_if #(
    parameter int N_LED = 10
);
    logic [1:0]       iMODE;
    logic [3:0]       iSPEED;
    logic             iPAUSE;
    logic [N_LED-1:0] oLED;
    logic             oDIR;
    logic             oTICK;

    modport master (
        output iMODE, iSPEED, iPAUSE,
        input  oLED, oDIR, oTICK
    );

    modport slave (
        input  iMODE, iSPEED, iPAUSE,
        output oLED, oDIR, oTICK
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled stepping of bounce, rotate-left/right and bar-fill patterns.
// All state lives on iCLK; the prescaler only produces an enable, never a clock.
module led_pattern_engine #(
    parameter int N_LED = 10,
    parameter int SEG_W = 3,
    parameter int DIV_W = 21
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    led_pattern_engine_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROL    = 2'b01,
        MODE_ROR    = 2'b10,
        MODE_BAR    = 2'b11
    } mode_t;

    localparam logic [N_LED-1:0] SEG_INIT = {{(N_LED-SEG_W){1'b0}}, {SEG_W{1'b1}}};

    mode_t            r_mode;
    logic [DIV_W-1:0] r_cnt;
    logic [N_LED-1:0] r_led;
    logic             r_dir;
    logic             r_tick;

    logic [DIV_W-1:0] w_ones;
    logic [DIV_W-1:0] w_limit;
    logic             w_mode_chg;

    always_comb begin
        w_ones     = '1;
        w_limit    = (32'(bus.iSPEED) >= DIV_W) ? '0 : (w_ones >> bus.iSPEED);
        w_mode_chg = (bus.iMODE != r_mode);
    end

    // Mode load outranks pause, which outranks the prescaler compare.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_mode <= MODE_BOUNCE;
            r_cnt  <= '0;
            r_led  <= SEG_INIT;
            r_dir  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_mode <= mode_t'(bus.iMODE);
            if (w_mode_chg) begin
                r_cnt  <= '0;
                r_dir  <= 1'b0;
                r_tick <= 1'b0;
                r_led  <= (mode_t'(bus.iMODE) == MODE_BAR) ? '0 : SEG_INIT;
            end else if (bus.iPAUSE) begin
                r_tick <= 1'b0;
            end else if (r_cnt >= w_limit) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                case (r_mode)
                    MODE_BOUNCE: begin
                        if (!r_dir) begin
                            if (r_led[N_LED-1]) begin
                                r_dir <= 1'b1;
                                r_led <= r_led >> 1;
                            end else begin
                                r_led <= r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                r_dir <= 1'b0;
                                r_led <= r_led << 1;
                            end else begin
                                r_led <= r_led >> 1;
                            end
                        end
                    end
                    MODE_ROL: begin
                        r_dir <= 1'b0;
                        r_led <= {r_led[N_LED-2:0], r_led[N_LED-1]};
                    end
                    MODE_ROR: begin
                        r_dir <= 1'b0;
                        r_led <= {r_led[0], r_led[N_LED-1:1]};
                    end
                    default: begin
                        r_dir <= 1'b0;
                        r_led <= (&r_led) ? '0 : {r_led[N_LED-2:0], 1'b1};
                    end
                endcase
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_tick <= 1'b0;
            end
        end
    end

    assign bus.oLED  = r_led;
    assign bus.oDIR  = r_dir;
    assign bus.oTICK = r_tick;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine at N_LED=8, SEG_W=3, DIV_W=4.
module tb_led_pattern_engine;
    logic iCLK;
    logic iRST_n;
    int   n_checks;
    int   n_errors;
    int   n;

    led_pattern_engine_if #(.N_LED(8)) bus ();

    led_pattern_engine #(
        .N_LED (8),
        .SEG_W (3),
        .DIV_W (4)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_tick(input int max_edges, output int edges);
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            tick_edge();
            if (bus.oTICK) begin
                edges = i;
                break;
            end
        end
    endtask

    logic [7:0] bounce_led [11] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70,
                                    8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E};
    logic       bounce_dir [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ror_led    [3]  = '{8'h83, 8'hC1, 8'hE0};
    logic [7:0] bar_led    [8]  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        iRST_n     = 1'b0;
        bus.iMODE  = 2'b00;
        bus.iSPEED = 4'd0;
        bus.iPAUSE = 1'b0;

        // Reset state and the LIMIT=15 tick period
        #12;
        check("rst_led", 32'(bus.oLED), 32'h07);
        check("rst_dir", 32'(bus.oDIR), 32'h0);
        check("rst_tick", 32'(bus.oTICK), 32'h0);
        #11 iRST_n = 1'b1;
        wait_tick(40, n);
        check("first_tick_edges", n, 16);
        check("first_tick_led", 32'(bus.oLED), 32'h0E);
        wait_tick(40, n);
        check("tick_period", n, 16);
        check("second_tick_led", 32'(bus.oLED), 32'h1C);
        tick_edge();
        check("tick_one_cycle", 32'(bus.oTICK), 32'h0);

        // Bounce with LIMIT=0
        #1 iRST_n = 1'b0;
        bus.iSPEED = 4'd4;
        #2 iRST_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick_edge();
            check($sformatf("bounce_led%0d", i), 32'(bus.oLED), 32'(bounce_led[i]));
            check($sformatf("bounce_dir%0d", i), 32'(bus.oDIR), 32'(bounce_dir[i]));
            check($sformatf("bounce_tick%0d", i), 32'(bus.oTICK), 32'h1);
        end

        // Mode switch to rotate-right mid-run
        bus.iMODE = 2'b10;
        tick_edge();
        check("ror_load_led", 32'(bus.oLED), 32'h07);
        check("ror_load_tick", 32'(bus.oTICK), 32'h0);
        check("ror_load_dir", 32'(bus.oDIR), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            check($sformatf("ror_led%0d", i), 32'(bus.oLED), 32'(ror_led[i]));
            check($sformatf("ror_dir%0d", i), 32'(bus.oDIR), 32'h0);
        end

        // Mode switch mid-count clears the prescaler
        bus.iSPEED = 4'd2;
        tick_edge();
        tick_edge();
        bus.iMODE = 2'b11;
        tick_edge();
        check("bar_load_led", 32'(bus.oLED), 32'h00);
        check("bar_load_tick", 32'(bus.oTICK), 32'h0);
        wait_tick(10, n);
        check("bar_cnt_cleared", n, 4);
        check("bar_first", 32'(bus.oLED), 32'h01);
        bus.iSPEED = 4'd4;
        for (int i = 0; i < 8; i++) begin
            tick_edge();
            check($sformatf("bar_led%0d", i), 32'(bus.oLED), 32'(bar_led[i]));
        end

        // Pause mid-count at LIMIT=3
        bus.iSPEED = 4'd2;
        wait_tick(10, n);
        check("pause_pre_tick", n, 4);
        check("pause_pre_led", 32'(bus.oLED), 32'h01);
        tick_edge();
        tick_edge();
        bus.iPAUSE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_edge();
            check($sformatf("paused_tick%0d", i), 32'(bus.oTICK), 32'h0);
            check($sformatf("paused_led%0d", i), 32'(bus.oLED), 32'h01);
        end
        bus.iPAUSE = 1'b0;
        wait_tick(10, n);
        check("resume_remaining", n, 2);
        check("resume_led", 32'(bus.oLED), 32'h03);

        // Mode load wins over pause
        bus.iPAUSE = 1'b1;
        bus.iMODE  = 2'b00;
        tick_edge();
        check("pause_mode_led", 32'(bus.oLED), 32'h07);
        tick_edge();
        check("pause_hold_led", 32'(bus.oLED), 32'h07);
        check("pause_hold_tick", 32'(bus.oTICK), 32'h0);
        bus.iPAUSE = 1'b0;

        // Asynchronous reset while bouncing toward LSB
        bus.iSPEED = 4'd4;
        for (int i = 0; i < 6; i++) tick_edge();
        check("pre_async_led", 32'(bus.oLED), 32'h70);
        check("pre_async_dir", 32'(bus.oDIR), 32'h1);
        #2 iRST_n = 1'b0;
        #1;
        check("async_led", 32'(bus.oLED), 32'h07);
        check("async_dir", 32'(bus.oDIR), 32'h0);
        check("async_tick", 32'(bus.oTICK), 32'h0);

        // Non-bounce mode held through reset is loaded on the first edge
        bus.iMODE = 2'b11;
        #1 iRST_n = 1'b1;
        tick_edge();
        check("post_rst_load_led", 32'(bus.oLED), 32'h00);
        check("post_rst_load_tick", 32'(bus.oTICK), 32'h0);
        tick_edge();
        check("post_rst_step_led", 32'(bus.oLED), 32'h01);
        check("post_rst_step_tick", 32'(bus.oTICK), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
